// File: rtl/irq_dispatch_12.sv
// rtl/irq_dispatch_12.sv - 12-source edge-latched interrupt dispatcher with offer/service handshake
module irq_dispatch_12 #(
  parameter logic [11:0] PolarityMask = 12'h000
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [11:0] Request,
  input  logic [11:0] Enable_Mask,
  input  logic        Ack,
  input  logic        Done,
  output logic        Irq,
  output logic [3:0]  Source_Id,
  output logic [11:0] Grant,
  output logic [11:0] Pending
);

  typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;

  state_t      state;
  logic [11:0] eff;
  logic [11:0] prev;
  logic [11:0] rise;
  logic [11:0] cand;
  logic [11:0] done_clr;
  logic [3:0]  win;

  assign eff  = Request ^ PolarityMask;
  assign rise = eff & ~prev;
  assign cand = Pending & Enable_Mask;

  // Downward scan so the lowest set index is the last one written.
  always_comb begin
    win = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (cand[i]) win = 4'(i);
    end
  end

  always_comb begin
    done_clr = 12'h000;
    if (state == SERVICE && Done) done_clr = 12'd1 << Source_Id;
  end

  // The set term is OR'd in last, so a new edge wins over a same-cycle clear.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      prev    <= 12'h000;
      Pending <= 12'h000;
    end else begin
      prev    <= eff;
      Pending <= (Pending & ~done_clr) | rise;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      Irq       <= 1'b0;
      Source_Id <= 4'd0;
      Grant     <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            state     <= OFFER;
            Source_Id <= win;
            Irq       <= 1'b1;
          end
        end
        OFFER: begin
          if (Ack) begin
            state <= SERVICE;
            Irq   <= 1'b0;
            Grant <= 12'd1 << Source_Id;
          end else if (!Enable_Mask[Source_Id]) begin
            state     <= IDLE;
            Irq       <= 1'b0;
            Source_Id <= 4'd0;
          end
        end
        SERVICE: begin
          if (Done) begin
            state     <= IDLE;
            Grant     <= 12'h000;
            Source_Id <= 4'd0;
          end
        end
        default: begin
          state     <= IDLE;
          Irq       <= 1'b0;
          Source_Id <= 4'd0;
          Grant     <= 12'h000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_dispatch_12.sv
// tb/tb_irq_dispatch_12.sv - directed self-checking bench for irq_dispatch_12
module tb_irq_dispatch_12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] req;
  logic [11:0] en;
  logic        ack;
  logic        done;
  logic        irq;
  logic [3:0]  sid;
  logic [11:0] grant;
  logic [11:0] pending;

  logic [11:0] pol_req;
  logic        pol_irq;
  logic [3:0]  pol_sid;
  logic [11:0] pol_grant;
  logic [11:0] pol_pending;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  irq_dispatch_12 dut (
    .Clock(clk), .Reset_n(rst_n), .Request(req), .Enable_Mask(en),
    .Ack(ack), .Done(done), .Irq(irq), .Source_Id(sid),
    .Grant(grant), .Pending(pending)
  );

  // Second instance exercises the polarity inversion; kept disabled so it never offers.
  irq_dispatch_12 #(.PolarityMask(12'h001)) dut_pol (
    .Clock(clk), .Reset_n(rst_n), .Request(pol_req), .Enable_Mask(12'h000),
    .Ack(ack), .Done(done), .Irq(pol_irq), .Source_Id(pol_sid),
    .Grant(pol_grant), .Pending(pol_pending)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic i, input logic [3:0] s,
                         input logic [11:0] g, input logic [11:0] p);
    chk({tag, "_irq"}, {11'd0, irq}, {11'd0, i});
    chk({tag, "_sid"}, {8'd0, sid}, {8'd0, s});
    chk({tag, "_grant"}, grant, g);
    chk({tag, "_pend"}, pending, p);
  endtask

  initial begin
    rst_n = 1'b0; req = 12'h000; en = 12'hFFF; ack = 1'b0; done = 1'b0;
    pol_req = 12'h001;
    #12;
    chk_out("reset", 1'b0, 4'd0, 12'h000, 12'h000);
    chk("reset_pol_pend", pol_pending, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single request on source 2
    req = 12'h004;
    tick();
    chk_out("single_clk1", 1'b0, 4'd0, 12'h000, 12'h004);
    tick();
    chk_out("single_clk2", 1'b1, 4'd2, 12'h000, 12'h004);
    ack = 1'b1; tick(); ack = 1'b0;
    chk_out("single_ack", 1'b0, 4'd2, 12'h004, 12'h004);
    done = 1'b1; tick(); done = 1'b0;
    chk_out("single_done", 1'b0, 4'd0, 12'h000, 12'h000);
    req = 12'h000; tick();

    // Priority: sources 0 and 11 together
    req = 12'h801;
    tick();
    chk("prio_pend", pending, 12'h801);
    tick();
    chk_out("prio_offer0", 1'b1, 4'd0, 12'h000, 12'h801);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("prio_grant0", grant, 12'h001);
    done = 1'b1; tick(); done = 1'b0;
    chk_out("prio_gap", 1'b0, 4'd0, 12'h000, 12'h800);
    tick();
    chk_out("prio_offer11", 1'b1, 4'd11, 12'h000, 12'h800);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("prio_grant11", grant, 12'h800);
    done = 1'b1; tick(); done = 1'b0;
    chk_out("prio_done11", 1'b0, 4'd0, 12'h000, 12'h000);
    req = 12'h000; tick();

    // Mask drop before Ack, stray Ack/Done in IDLE, then re-enable
    req = 12'h008;
    tick(); tick();
    chk_out("mask_offer", 1'b1, 4'd3, 12'h000, 12'h008);
    en = 12'hFF7; tick();
    chk_out("mask_drop", 1'b0, 4'd0, 12'h000, 12'h008);
    ack = 1'b1; tick(); ack = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    chk_out("mask_stray", 1'b0, 4'd0, 12'h000, 12'h008);
    en = 12'hFFF; tick();
    chk_out("mask_reoffer", 1'b1, 4'd3, 12'h000, 12'h008);
    ack = 1'b1; tick(); ack = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    chk("mask_done_pend", pending, 12'h000);
    req = 12'h000; tick();

    // Polarity: inverted line held high gives no edge, falling gives one
    chk("pol_held", pol_pending, 12'h000);
    pol_req = 12'h000; tick();
    chk("pol_fall", pol_pending, 12'h001);
    chk("pol_irq", {7'd0, pol_irq, pol_sid}, 12'h000);
    chk("pol_grant", pol_grant, 12'h000);

    // Ack+Done together in OFFER, then set/clear collision on source 5
    req = 12'h020;
    tick(); tick();
    chk_out("coll_offer", 1'b1, 4'd5, 12'h000, 12'h020);
    ack = 1'b1; done = 1'b1; tick(); ack = 1'b0; done = 1'b0;
    chk_out("coll_ackdone", 1'b0, 4'd5, 12'h020, 12'h020);
    req = 12'h000; tick();
    req = 12'h020; done = 1'b1; tick(); done = 1'b0;
    chk_out("coll_setwins", 1'b0, 4'd0, 12'h000, 12'h020);
    tick();
    chk_out("coll_reoffer", 1'b1, 4'd5, 12'h000, 12'h020);
    ack = 1'b1; tick(); ack = 1'b0;
    req = 12'h000; done = 1'b1; tick(); done = 1'b0;
    chk("coll_done_pend", pending, 12'h000);

    // Enable change ignored in SERVICE, then async reset mid-SERVICE
    req = 12'h010;
    tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("rst_grant", grant, 12'h010);
    en = 12'h000; tick();
    chk_out("svc_mask_ignored", 1'b0, 4'd4, 12'h010, 12'h010);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 4'd0, 12'h000, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
